// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit eight-op logic unit with valid/ready handshake, all-ones match flag and saturating match counter
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_match,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             cnt_clear
);
  logic [WIDTH-1:0] f;
  logic in_xfer, out_xfer;
  assign in_ready = !rst && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  always_comb
    f = in_op == 3'd0 ? in_a & in_b :
        in_op == 3'd1 ? in_a | in_b :
        in_op == 3'd2 ? in_a ^ in_b :
        in_op == 3'd3 ? ~(in_a ^ in_b) :
        in_op == 3'd4 ? ~(in_a & in_b) :
        in_op == 3'd5 ? ~(in_a | in_b) :
        in_op == 3'd6 ? ~in_a : in_a;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_match  <= 1'b0;
      match_cnt  <= '0;
    end else begin
      if (in_xfer) begin
        out_result <= f;
        out_match  <= &f;
        out_valid  <= 1'b1;
      end else if (out_xfer)
        out_valid <= 1'b0;
      match_cnt <= cnt_clear ? '0 :
                   (out_xfer && out_match && !(&match_cnt)) ? match_cnt + CNT_W'(1) : match_cnt;
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench driving WIDTH=8/CNT_W=16, WIDTH=8/CNT_W=2 and WIDTH=1 builds in lockstep
module tb_logic_unit_pipe;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, cnt_clear = 0;
  logic [7:0] in_a = 0, in_b = 0, cur_exp = 0;
  logic [2:0] in_op = 0;
  logic [7:0] r8, r2;
  logic [0:0] r1;
  logic m8, m2, m1, v8, v2, v1, ir8, ir2, ir1;
  logic [15:0] c16, c1;
  logic [1:0] c2;
  int n_cmp = 0, n_bad = 0;
  int cnt16 = 0, cnt2 = 0, cnt1 = 0;
  logic [7:0] q[$];
  logic [7:0] e;
  bit acc = 0, rdy, xf;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(v8), .out_ready(out_ready), .out_result(r8), .out_match(m8),
    .match_cnt(c16), .cnt_clear(cnt_clear));
  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(v2), .out_ready(out_ready), .out_result(r2), .out_match(m2),
    .match_cnt(c2), .cnt_clear(cnt_clear));
  logic_unit_pipe #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_a(in_a[0:0]), .in_b(in_b[0:0]),
    .in_op(in_op), .out_valid(v1), .out_ready(out_ready), .out_result(r1), .out_match(m1),
    .match_cnt(c1), .cnt_clear(cnt_clear));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    acc = 0;
    xf = 0;
    if (rst) begin
      chk("in_ready_in_reset", {29'b0, ir8, ir2, ir1}, 0);
      q.delete();
      cnt16 = 0;
      cnt2 = 0;
      cnt1 = 0;
    end else begin
      rdy = q.size() == 0 || out_ready;
      chk("in_ready", {29'b0, ir8, ir2, ir1}, {29'b0, {3{rdy}}});
      chk("out_valid", {29'b0, v8, v2, v1}, {29'b0, {3{q.size() != 0}}});
      if (q.size() != 0) begin
        e = q[0];
        chk("out_result_w8", {24'b0, r8}, {24'b0, e});
        chk("out_result_c2", {24'b0, r2}, {24'b0, e});
        chk("out_result_w1", {31'b0, r1}, {31'b0, e[0]});
        chk("out_match", {29'b0, m8, m2, m1}, {29'b0, &e, &e, e[0]});
      end
      chk("match_cnt_w8", {16'b0, c16}, cnt16);
      chk("match_cnt_c2", {30'b0, c2}, cnt2);
      chk("match_cnt_w1", {16'b0, c1}, cnt1);
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front();
        xf = 1;
      end
      cnt16 = cnt_clear ? 0 : (xf && &e) ? (cnt16 == 65535 ? cnt16 : cnt16 + 1) : cnt16;
      cnt2  = cnt_clear ? 0 : (xf && &e) ? (cnt2 == 3 ? cnt2 : cnt2 + 1) : cnt2;
      cnt1  = cnt_clear ? 0 : (xf && e[0]) ? (cnt1 == 65535 ? cnt1 : cnt1 + 1) : cnt1;
      if (in_valid && rdy) begin
        q.push_back(cur_exp);
        acc = 1;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [7:0] exp);
    bit got = 0;
    in_a = a;
    in_b = b;
    in_op = op;
    cur_exp = exp;
    in_valid = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      got = acc;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no transfer expected one for op %0d", op);
    end
    #1 in_valid = 0;
  endtask

  task automatic drain;
    out_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {v8, v2, v1, m8, m2, m1, r8, r2, r1}, 0);
    chk("reset_cnt", {c16, c2, c1}, 0);
    rst = 0;
    out_ready = 1;
    send(8'hA5, 8'hA5, 3'd3, 8'hFF);
    drain();
    chk("t1_cnt", {16'b0, c16}, 1);
    send(8'hC3, 8'h0F, 3'd0, 8'h03);
    send(8'hC3, 8'h0F, 3'd1, 8'hCF);
    send(8'hC3, 8'h0F, 3'd2, 8'hCC);
    send(8'hC3, 8'h0F, 3'd3, 8'h33);
    send(8'hC3, 8'h0F, 3'd4, 8'hFC);
    send(8'hC3, 8'h0F, 3'd5, 8'h30);
    send(8'hC3, 8'h0F, 3'd6, 8'h3C);
    send(8'hC3, 8'h0F, 3'd7, 8'hC3);
    send(8'h00, 8'h00, 3'd3, 8'hFF);
    send(8'h00, 8'h01, 3'd3, 8'hFE);
    send(8'h01, 8'h00, 3'd3, 8'hFE);
    send(8'h01, 8'h01, 3'd3, 8'hFF);
    drain();
    cnt_clear = 1;
    @(posedge clk);
    #1 cnt_clear = 0;
    for (int i = 0; i < 5; i++) send(8'h5A, 8'h5A, 3'd3, 8'hFF);
    chk("t4_sat_c2", {30'b0, c2}, 3);
    cnt_clear = 1;
    send(8'h3C, 8'hC3, 3'd1, 8'hFF);
    cnt_clear = 0;
    chk("t4_clear_c2", {30'b0, c2}, 0);
    drain();
    chk("t4_after_clear_c2", {30'b0, c2}, 1);
    out_ready = 0;
    fork
      begin
        send(8'hC3, 8'h0F, 3'd0, 8'h03);
        send(8'hC3, 8'h0F, 3'd1, 8'hCF);
        send(8'hC3, 8'h0F, 3'd2, 8'hCC);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    send(8'hF0, 8'h0F, 3'd1, 8'hFF);
    drain();
    out_ready = 0;
    send(8'h66, 8'h66, 3'd3, 8'hFF);
    rst = 1;
    @(posedge clk);
    #1;
    chk("t5_valid", {29'b0, v8, v2, v1}, 0);
    chk("t5_result", {15'b0, r8, r2, r1}, 0);
    chk("t5_cnt", {c16, c1}, 0);
    chk("t5_cnt_c2", {30'b0, c2}, 0);
    rst = 0;
    out_ready = 1;
    send(8'h0F, 8'hF0, 3'd5, 8'h00);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
